// File: rtl/mcpu_control_fsm_if.sv
// rtl/mcpu_control_fsm_if.sv - control bus between the MCPU control FSM and its datapath
interface mcpu_control_fsm_if;
    logic [5:0] i_op;
    logic [5:0] i_funct;
    logic       i_br;
    logic       PCWrite;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [3:0] ALUControl;
    logic       o_illegal;

    modport master (
        input  i_op, i_funct, i_br,
        output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, o_illegal
    );

    modport slave (
        output i_op, i_funct, i_br,
        input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, o_illegal
    );
endinterface

// File: rtl/mcpu_control_fsm.sv
// rtl/mcpu_control_fsm.sv - multicycle MCPU control unit (fetch/decode/execute/mem/writeback)
module mcpu_control_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    mcpu_control_fsm_if.master         bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BR    = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_SLLV = 4'b1110;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       w_mem_last;
    logic       w_funct_ok;
    logic [3:0] w_funct_alu;

    assign w_mem_last = (r_cnt == LAST_WAIT);

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (bus.i_funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b100110: w_funct_alu = ALU_XOR;
            6'b101010: w_funct_alu = ALU_SLT;
            6'b000100: w_funct_alu = ALU_SLLV;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // Wait counter only advances while a memory state holds; any transition clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_mem_last) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BR:        w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.i_op == OP_LW)      w_next = S_MEMRD;
                else if (bus.i_op == OP_SW) w_next = S_MEMWR;
                else                        w_next = S_FETCH;
            end
            S_MEMRD:    if (w_mem_last) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR:    w_next = S_FETCH;
            S_EXEC:     w_next = w_funct_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEXEC: w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // Outputs are gated by reset_n so nothing fires while reset is held mid-instruction.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.o_illegal  = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = w_mem_last;
                    bus.PCWrite = w_mem_last;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    case (bus.i_op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BR, OP_ADDI, OP_J: bus.o_illegal = 1'b0;
                        default: bus.o_illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD:  bus.IorD = 1'b1;
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_EXEC: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUControl = w_funct_alu;
                    bus.o_illegal  = !w_funct_ok;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUControl = ALU_SUB;
                    bus.PCSrc      = 2'b01;
                    bus.PCWrite    = bus.i_br;
                end
                S_ADDIEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_ADDIWB: bus.RegWrite = 1'b1;
                S_JUMP: begin
                    bus.PCSrc   = 2'b10;
                    bus.PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// tb/tb_mcpu_control_fsm.sv - directed self-checking bench for mcpu_control_fsm at MEM_LAT 1 and 3
module tb_mcpu_control_fsm;

    logic clk = 1'b0;
    logic rstn_a;
    logic rstn_b;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mcpu_control_fsm_if ifa ();
    mcpu_control_fsm_if ifb ();

    mcpu_control_fsm #(.MEM_LAT(1)) dut_a (.clk(clk), .reset_n(rstn_a), .bus(ifa));
    mcpu_control_fsm #(.MEM_LAT(3)) dut_b (.clk(clk), .reset_n(rstn_b), .bus(ifb));

    wire [16:0] w_outs_a = {ifa.PCWrite, ifa.IorD, ifa.MemWrite, ifa.IRWrite, ifa.RegDst,
                            ifa.MemtoReg, ifa.RegWrite, ifa.ALUSrcA, ifa.ALUSrcB, ifa.PCSrc,
                            ifa.ALUControl, ifa.o_illegal};
    wire [16:0] w_outs_b = {ifb.PCWrite, ifb.IorD, ifb.MemWrite, ifb.IRWrite, ifb.RegDst,
                            ifb.MemtoReg, ifb.RegWrite, ifb.ALUSrcA, ifb.ALUSrcB, ifb.PCSrc,
                            ifb.ALUControl, ifb.o_illegal};

    function automatic logic [16:0] mk(input logic pcw, iord, mw, irw, rd, m2r, rw, asa,
                                       input logic [1:0] asb, pcs, input logic [3:0] alu,
                                       input logic ill);
        return {pcw, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, ill};
    endfunction

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic step(input bit sel_b, input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        @(negedge clk);
        obs = sel_b ? w_outs_b : w_outs_a;
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    logic [16:0] RST, F_WAIT, F_LAST, DEC, DEC_ILL, MADR, MRD, MWB, MWR, AWB, AEX, AWB_I;
    logic [5:0]  fn [7];
    logic [3:0]  cd [7];

    initial begin
        RST     = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0010,0);
        F_WAIT  = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0);
        F_LAST  = mk(1,0,0,1,0,0,0,0,2'b01,2'b00,4'b0010,0);
        DEC     = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0);
        DEC_ILL = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,1);
        MADR    = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0);
        MRD     = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,4'b0010,0);
        MWB     = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0010,0);
        MWR     = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,4'b0010,0);
        AWB     = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0010,0);
        AEX     = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0);
        AWB_I   = mk(0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0010,0);
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b000100};
        cd = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1011,   4'b0111,   4'b1110};

        rstn_a = 1'b0;
        rstn_b = 1'b0;
        ifa.i_op = 6'b000000; ifa.i_funct = 6'b100000; ifa.i_br = 1'b0;
        ifb.i_op = 6'b100011; ifb.i_funct = 6'b000000; ifb.i_br = 1'b0;
        @(posedge clk);
        #1;

        step(0, "a_reset0", RST);
        step(0, "a_reset1", RST);
        rstn_a = 1'b1;

        for (int i = 0; i < 7; i++) begin
            ifa.i_op = 6'b000000;
            ifa.i_funct = fn[i];
            step(0, $sformatf("r%0d_fetch", i), F_LAST);
            step(0, $sformatf("r%0d_decode", i), DEC);
            step(0, $sformatf("r%0d_exec", i), mk(0,0,0,0,0,0,0,1,2'b00,2'b00,cd[i],0));
            step(0, $sformatf("r%0d_aluwb", i), AWB);
        end

        ifa.i_op = 6'b001000;
        step(0, "addi_fetch", F_LAST);
        step(0, "addi_decode", DEC);
        step(0, "addi_exec", AEX);
        step(0, "addi_wb", AWB_I);

        ifa.i_op = 6'b000100;
        ifa.i_br = 1'b1;
        step(0, "br1_fetch", F_LAST);
        step(0, "br1_decode", DEC);
        step(0, "br1_branch", mk(1,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,0));
        ifa.i_br = 1'b0;
        step(0, "br0_fetch", F_LAST);
        step(0, "br0_decode", DEC);
        step(0, "br0_branch", mk(0,0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,0));

        ifa.i_op = 6'b000010;
        step(0, "j_fetch", F_LAST);
        step(0, "j_decode", DEC);
        step(0, "j_jump", mk(1,0,0,0,0,0,0,0,2'b00,2'b10,4'b0010,0));

        ifa.i_op = 6'b111111;
        step(0, "illop_fetch", F_LAST);
        step(0, "illop_decode", DEC_ILL);

        ifa.i_op = 6'b000000;
        ifa.i_funct = 6'b111111;
        step(0, "illfn_fetch", F_LAST);
        step(0, "illfn_decode", DEC);
        step(0, "illfn_exec", mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0010,1));

        ifa.i_op = 6'b100011;
        step(0, "lw1_fetch", F_LAST);
        step(0, "lw1_decode", DEC);
        step(0, "lw1_memadr", MADR);
        step(0, "lw1_memrd", MRD);
        step(0, "lw1_memwb", MWB);
        step(0, "lw1_next_fetch", F_LAST);

        rstn_b = 1'b1;
        ifb.i_op = 6'b100011;
        step(1, "lw3_fetch0", F_WAIT);
        step(1, "lw3_fetch1", F_WAIT);
        step(1, "lw3_fetch2", F_LAST);
        step(1, "lw3_decode", DEC);
        step(1, "lw3_memadr", MADR);
        step(1, "lw3_memrd0", MRD);
        step(1, "lw3_memrd1", MRD);
        step(1, "lw3_memrd2", MRD);
        step(1, "lw3_memwb", MWB);

        ifb.i_op = 6'b101011;
        step(1, "sw3_fetch0", F_WAIT);
        step(1, "sw3_fetch1", F_WAIT);
        step(1, "sw3_fetch2", F_LAST);
        step(1, "sw3_decode", DEC);
        step(1, "sw3_memadr", MADR);
        step(1, "sw3_memwr", MWR);

        ifb.i_op = 6'b100011;
        step(1, "rs_fetch0", F_WAIT);
        step(1, "rs_fetch1", F_WAIT);
        step(1, "rs_fetch2", F_LAST);
        step(1, "rs_decode", DEC);
        step(1, "rs_memadr", MADR);
        step(1, "rs_memrd0", MRD);
        rstn_b = 1'b0;
        step(1, "rs_hold0", RST);
        step(1, "rs_hold1", RST);
        step(1, "rs_hold2", RST);
        rstn_b = 1'b1;
        step(1, "rs_after0", F_WAIT);
        step(1, "rs_after1", F_WAIT);
        step(1, "rs_after2", F_LAST);
        step(1, "rs_after_decode", DEC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
